// File: rtl/mem_access_unit.sv
// Load/store unit between the MEM stage and a word-only data memory.
// Sub-word stores take a read-modify-write pass through the MERGE state.
module mem_access_unit #(
    parameter bit ALIGN_CHECK = 1'b1
) (
    input  logic        clock,
    input  logic        resetN,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [1:0]  size,
    input  logic        unsignedLoad,
    input  logic [31:0] byteAddr,
    input  logic [31:0] storeData,
    output logic [31:0] loadData,
    output logic        stall,
    output logic        alignError,
    output logic        errorSticky,
    output logic [31:0] errorAddr,
    output logic [31:0] memAddress,
    output logic [31:0] memWriteData,
    output logic        memWriteSign,
    output logic        memReadSign,
    input  logic [31:0] memReadData
);

    typedef enum logic {IDLE, MERGE} stateT;

    stateT       state;
    stateT       stateNext;
    logic [31:0] capWord;
    logic [29:0] capIndex;
    logic [1:0]  capLane;
    logic [1:0]  capSize;
    logic [15:0] capData;

    logic        isWord;
    logic        isHalf;
    logic        misaligned;
    logic        active;
    logic        doLoad;
    logic        doStore;
    logic        subStore;
    logic [7:0]  laneByte;
    logic [15:0] laneHalf;
    logic        extByte;
    logic        extHalf;
    logic [31:0] mergedWord;

    assign isWord = size[1];
    assign isHalf = (size == 2'b01);

    assign misaligned = ALIGN_CHECK &&
        ((isWord && (byteAddr[1:0] != 2'b00)) || (isHalf && byteAddr[0]));

    // Requests only act in IDLE and outside reset; MERGE ignores them.
    assign active     = resetN && (state == IDLE);
    assign alignError = active && (memRead || memWrite) && misaligned;
    assign doStore    = active && memWrite && !misaligned;
    assign doLoad     = active && memRead && !memWrite && !misaligned;
    assign subStore   = doStore && !isWord;

    assign laneByte = memReadData[{byteAddr[1:0], 3'b000} +: 8];
    assign laneHalf = memReadData[{byteAddr[1], 4'b0000} +: 16];
    assign extByte  = !unsignedLoad && laneByte[7];
    assign extHalf  = !unsignedLoad && laneHalf[15];

    always_comb begin
        loadData = 32'h0;
        if (doLoad) begin
            unique case (1'b1)
                isWord:  loadData = memReadData;
                isHalf:  loadData = {{16{extHalf}}, laneHalf};
                default: loadData = {{24{extByte}}, laneByte};
            endcase
        end
    end

    always_comb begin
        mergedWord = capWord;
        if (capSize == 2'b00) begin
            mergedWord[{capLane, 3'b000} +: 8] = capData[7:0];
        end else begin
            mergedWord[{capLane[1], 4'b0000} +: 16] = capData;
        end
    end

    always_comb begin
        stateNext    = IDLE;
        stall        = subStore;
        memReadSign  = doLoad || subStore;
        memWriteSign = doStore && isWord;
        memWriteData = storeData;
        memAddress   = {2'b00, byteAddr[31:2]};
        if (state == MERGE) begin
            // Reset during MERGE drops the pending write.
            memWriteSign = resetN;
            memWriteData = mergedWord;
            memAddress   = {2'b00, capIndex};
        end else if (subStore) begin
            stateNext = MERGE;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetN) begin
            state       <= IDLE;
            errorSticky <= 1'b0;
            errorAddr   <= 32'h0;
            capWord     <= 32'h0;
            capIndex    <= 30'h0;
            capLane     <= 2'b00;
            capSize     <= 2'b00;
            capData     <= 16'h0;
        end else begin
            state <= stateNext;
            if (alignError) begin
                errorSticky <= 1'b1;
                if (!errorSticky) begin
                    errorAddr <= byteAddr;
                end
            end
            if (subStore) begin
                capWord  <= memReadData;
                capIndex <= byteAddr[31:2];
                capLane  <= byteAddr[1:0];
                capSize  <= size;
                capData  <= storeData[15:0];
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed plan plus random traffic checked
// against a byte-array reference memory.
module tb_mem_access_unit;

    logic        clock;
    logic        resetN;
    logic        memRead;
    logic        memWrite;
    logic [1:0]  size;
    logic        unsignedLoad;
    logic [31:0] byteAddr;
    logic [31:0] storeData;
    logic [31:0] loadData;
    logic        stall;
    logic        alignError;
    logic        errorSticky;
    logic [31:0] errorAddr;
    logic [31:0] memAddress;
    logic [31:0] memWriteData;
    logic        memWriteSign;
    logic        memReadSign;
    logic [31:0] memReadData;

    logic [31:0] mem [256];
    logic [7:0]  refBytes [1024];
    bit          refSticky;
    logic [31:0] refErrAddr;
    int          errors;
    int          checks;
    int          stallHigh;
    logic [31:0] seen;

    mem_access_unit #(.ALIGN_CHECK(1'b1)) dut (
        .clock(clock), .resetN(resetN), .memRead(memRead),
        .memWrite(memWrite), .size(size), .unsignedLoad(unsignedLoad),
        .byteAddr(byteAddr), .storeData(storeData), .loadData(loadData),
        .stall(stall), .alignError(alignError), .errorSticky(errorSticky),
        .errorAddr(errorAddr), .memAddress(memAddress),
        .memWriteData(memWriteData), .memWriteSign(memWriteSign),
        .memReadSign(memReadSign), .memReadData(memReadData)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Word memory, written on the falling edge, read combinationally.
    always @(negedge clock) begin
        if (memWriteSign) mem[memAddress[7:0]] <= memWriteData;
    end
    assign memReadData = mem[memAddress[7:0]];

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int nBytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic bit isMis(input logic [1:0] sz, input logic [31:0] a);
        int n = nBytes(sz);
        return (a % n) != 0;
    endfunction

    function automatic logic [31:0] refLoad(input logic [31:0] a,
                                            input logic [1:0] sz,
                                            input bit uns);
        int n = nBytes(sz);
        logic [31:0] v = 0;
        for (int i = 0; i < n; i++)
            v = v | (32'(refBytes[a[9:0] + 10'(i)]) << (8 * i));
        if (!uns && n < 4 && v[8 * n - 1])
            v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    function automatic logic [31:0] refWord(input int idx);
        return {refBytes[4*idx+3], refBytes[4*idx+2],
                refBytes[4*idx+1], refBytes[4*idx]};
    endfunction

    task automatic refStore(input logic [31:0] a, input logic [1:0] sz,
                            input logic [31:0] d);
        for (int i = 0; i < nBytes(sz); i++)
            refBytes[a[9:0] + 10'(i)] = d[8*i +: 8];
    endtask

    // Starts at posedge+1, ends at a later posedge+1 with inputs idle.
    task automatic access(input bit rd, input bit wr, input logic [1:0] sz,
                          input bit uns, input logic [31:0] a,
                          input logic [31:0] d, output logic [31:0] ld);
        bit mis = isMis(sz, a);
        bit sub = wr && !mis && (sz[1] == 1'b0);
        memRead = rd; memWrite = wr; size = sz;
        unsignedLoad = uns; byteAddr = a; storeData = d;
        #2;
        ld = loadData;
        check("alignError", 32'(alignError), 32'((rd || wr) && mis));
        check("stall", 32'(stall), 32'(sub));
        check("memAddress", memAddress, a >> 2);
        if (stall) stallHigh++;
        if (rd && !wr)
            check("loadData", loadData, mis ? 32'h0 : refLoad(a, sz, uns));
        else
            check("loadDataIdle", loadData, 32'h0);
        check("wrEnable", 32'(memWriteSign), 32'(wr && !mis && sz[1]));
        if ((rd || wr) && mis && !refSticky) begin
            refSticky = 1'b1;
            refErrAddr = a;
        end
        if (wr && !mis) refStore(a, sz, d);
        if (sub) begin
            @(posedge clock); #1;
            #2;
            check("mergeStall", 32'(stall), 32'h0);
            check("mergeWrite", 32'(memWriteSign), 32'h1);
            check("mergeData", memWriteData, refWord(int'(a[9:2])));
        end
        @(posedge clock); #1;
        memRead = 1'b0; memWrite = 1'b0;
        check("errorSticky", 32'(errorSticky), 32'(refSticky));
        check("errorAddr", errorAddr, refErrAddr);
        if (wr && !mis)
            check("memWord", mem[a[9:2]], refWord(int'(a[9:2])));
    endtask

    initial begin
        errors = 0; checks = 0; stallHigh = 0;
        refSticky = 1'b0; refErrAddr = 0;
        for (int i = 0; i < 1024; i++) refBytes[i] = 8'h0;
        resetN = 1'b0; memRead = 1'b1; memWrite = 1'b0; size = 2'b10;
        unsignedLoad = 1'b0; byteAddr = 32'h3; storeData = 32'h0;
        repeat (2) @(posedge clock);
        #1;
        check("rstLoad", loadData, 32'h0);
        check("rstStall", 32'(stall), 32'h0);
        check("rstAlign", 32'(alignError), 32'h0);
        check("rstRdWr", {30'h0, memReadSign, memWriteSign}, 32'h0);
        check("rstSticky", 32'(errorSticky), 32'h0);
        check("rstErrAddr", errorAddr, 32'h0);
        resetN = 1'b1; memRead = 1'b0;

        for (int i = 0; i < 256; i++)
            access(0, 1, 2'b10, 0, 32'(4 * i), 32'h0, seen);

        stallHigh = 0;
        access(0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, seen);
        access(1, 0, 2'b10, 0, 32'h10, 32'h0, seen);
        check("lwDead", seen, 32'hDEADBEEF);
        check("mem4Dead", mem[4], 32'hDEADBEEF);
        check("noStall", 32'(stallHigh), 32'h0);

        access(0, 1, 2'b10, 0, 32'h10, 32'h11223344, seen);
        access(0, 1, 2'b00, 0, 32'h12, 32'h000000AB, seen);
        check("sbMem4", mem[4], 32'h11AB3344);
        check("sbStallOnce", 32'(stallHigh), 32'h1);
        access(1, 0, 2'b00, 0, 32'h12, 32'h0, seen);
        check("lb", seen, 32'hFFFFFFAB);
        access(1, 0, 2'b00, 1, 32'h12, 32'h0, seen);
        check("lbu", seen, 32'h000000AB);

        access(0, 1, 2'b01, 0, 32'h16, 32'h00008001, seen);
        check("shMem5", mem[5], 32'h80010000);
        access(1, 0, 2'b01, 0, 32'h16, 32'h0, seen);
        check("lh", seen, 32'hFFFF8001);
        access(1, 0, 2'b01, 1, 32'h16, 32'h0, seen);
        check("lhu", seen, 32'h00008001);

        access(1, 1, 2'b10, 0, 32'h30, 32'hCAFEF00D, seen);
        check("rdWrLoad", seen, 32'h0);
        check("rdWrMem", mem[12], 32'hCAFEF00D);

        access(0, 1, 2'b10, 0, 32'h21, 32'h12345678, seen);
        check("swMisMem", mem[8], 32'h0);
        check("swMisAddr", errorAddr, 32'h21);
        access(1, 0, 2'b01, 0, 32'h33, 32'h0, seen);
        check("keepAddr", errorAddr, 32'h21);
        check("keepSticky", 32'(errorSticky), 32'h1);

        memWrite = 1'b1; size = 2'b00; byteAddr = 32'h12;
        storeData = 32'h55;
        @(posedge clock); #1;
        resetN = 1'b0;
        #2;
        check("abortWrite", 32'(memWriteSign), 32'h0);
        check("abortStall", 32'(stall), 32'h0);
        @(posedge clock); #1;
        resetN = 1'b1; memWrite = 1'b0;
        refSticky = 1'b0; refErrAddr = 0;
        check("abortMem4", mem[4], 32'h11AB3344);
        check("abortSticky", 32'(errorSticky), 32'h0);
        access(1, 0, 2'b10, 0, 32'h10, 32'h0, seen);
        check("abortIdle", seen, 32'h11AB3344);

        stallHigh = 0;
        access(0, 1, 2'b00, 0, 32'h40, 32'h01, seen);
        access(0, 1, 2'b00, 0, 32'h41, 32'h02, seen);
        check("b2bLow", {16'h0, mem[16][15:0]}, 32'h0201);
        check("b2bStalls", 32'(stallHigh), 32'h2);

        for (int i = 0; i < 300; i++) begin
            logic [31:0] a = 32'($urandom_range(0, 1023));
            logic [1:0]  sz = 2'($urandom);
            int          op = $urandom_range(0, 9);
            bit          rd = (op < 5) || (op == 9);
            bit          wr = (op >= 5);
            access(rd, wr, sz, 1'($urandom), a, $urandom, seen);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

- Sits between the datapath's MEM stage and the word-only 256-entry data memory, and drives all of that memory's ports.
- Converts byte-addressed load/store requests (word, halfword, byte; signed or unsigned loads) into word-indexed memory accesses, with little-endian lane placement.
- Sub-word stores run as a two-cycle read-modify-write, with `stall` holding the datapath during the first cycle.
- Detects misaligned accesses and suppresses them, recording the first offending address.

## Interface

Parameters:
- `ALIGN_CHECK`, 1, 1 = misalignment detection and suppression enabled; 0 = low address bits ignored, no error.

Ports:
- `clock`  in  1  single clock; all state updates on posedge.
- `resetN`  in  1  reset, synchronous, active-low.
- `memRead`  in  1  load request this cycle.
- `memWrite`  in  1  store request this cycle.
- `size`  in  2  00 byte, 01 halfword, 10 word, 11 treated as word.
- `unsignedLoad`  in  1  1 = zero-extend sub-word loads, 0 = sign-extend.
- `byteAddr`  in  32  byte address from ALU.
- `storeData`  in  32  store operand; sub-word data taken from the low bits.
- `loadData`  out  32  extended load result, combinational.
- `stall`  out  1  datapath must hold PC and pipeline inputs.
- `alignError`  out  1  combinational; current request is misaligned.
- `errorSticky`  out  1  registered; set on first misaligned request.
- `errorAddr`  out  32  registered `byteAddr` of the first misaligned request.
- `memAddress`  out  32  word index to memory, = `byteAddr >> 2` (zero-filled).
- `memWriteData`  out  32  word to memory.
- `memWriteSign`  out  1  memory write enable; memory writes on the negedge.
- `memReadSign`  out  1  memory read strobe (informational).
- `memReadData`  in  32  memory read port, combinational.

## Operation

- States are IDLE and MERGE. Reset state is IDLE.
- Lane select is `byteAddr[1:0]`. Byte k occupies bits 8k+7:8k; halfword h occupies bits 16h+15:16h, with h = `byteAddr[1]`.
- Misalignment (only when `ALIGN_CHECK` = 1):
  - A word access is misaligned if `byteAddr[1:0]` != 0.
  - A halfword access is misaligned if `byteAddr[0]` != 0.
  - On a misaligned access: `alignError` = 1, no memory write, `loadData` = 0, and no RMW is started.
- Request priority: if `memRead` and `memWrite` are both 1, the store is performed and `loadData` = 0.

IDLE behaviour:
- Load: `memReadSign` = 1. `loadData` is the selected lane of `memReadData`, sign- or zero-extended per `unsignedLoad`. A word load passes through unchanged. Completes the same cycle; `stall` = 0.
- Word store: `memWriteSign` = 1, `memWriteData` = `storeData`. Completes the same cycle; `stall` = 0.
- Sub-word store:
  - Asserts `memReadSign` = 1 and `stall` = 1; `memWriteSign` = 0.
  - At posedge, captures `memReadData`, word index, lane, size and `storeData[15:0]` into internal registers, then moves to MERGE.
- Otherwise: all memory strobes are 0 and `memAddress` follows `byteAddr >> 2`.

MERGE behaviour:
- Drives `memAddress` from the captured index.
- `memWriteData` = captured word with the selected lane replaced by the captured byte or halfword; `memWriteSign` = 1.
- `stall` = 0, so the datapath advances at the next posedge.
- Returns to IDLE unconditionally. Requests presented during MERGE are ignored.

Error registers:
- `errorSticky` sets at the posedge of the first misaligned request and stays set until reset.
- `errorAddr` is loaded only when `errorSticky` is 0, so it holds the first offending address.

## Timing

While `resetN` = 0:
- `memWriteSign`, `memReadSign`, `stall`, `alignError` are all 0.
- `loadData` = 0.
- At the posedge, state <= IDLE, `errorSticky` <= 0, `errorAddr` <= 0, and capture registers <= 0.
- A reset asserted while in MERGE aborts the write: `memWriteSign` stays 0 and memory is unchanged.

Latency:
- Loads: 0 cycles (combinational through memory).
- Word stores: 1 cycle; memory updates at that cycle's negedge.
- Sub-word stores: 2 cycles; memory updates at the MERGE cycle's negedge.

Other timing rules:
- `stall` is high for exactly one cycle per sub-word store.
- Back-to-back sub-word stores run IDLE→MERGE→IDLE→MERGE, giving 4 cycles for two stores.
- A load immediately after a store sees the stored value, because memory updates at the negedge and is read combinationally.

## Test plan

- Word store `byteAddr`=0x10, `storeData`=0xDEADBEEF, then word load 0x10 → memory[4]=0xDEADBEEF, `loadData`=0xDEADBEEF, `stall` never high.
- Memory[4]=0x11223344; `sb` 0xAB at 0x12 → `stall` high one cycle, then memory[4]=0x11AB3344. Then `lb` 0x12 → 0xFFFFFFAB; `lbu` 0x12 → 0x000000AB.
- Memory[5]=0x00000000; `sh` 0x8001 at 0x16 → memory[5]=0x80010000. `lh` 0x16 → 0xFFFF8001; `lhu` 0x16 → 0x00008001.
- `sw` at 0x21 → `alignError`=1, no write, `errorSticky`=1, `errorAddr`=0x21. A later `lh` at 0x33 → `errorAddr` stays 0x21.
- `sb` at 0x12 with `resetN` dropped during MERGE → `memWriteSign` stays 0, memory[4] unchanged, state IDLE, `errorSticky`=0.
- Back-to-back `sb` 0x01 at 0x40 then `sb` 0x02 at 0x41 → memory[16] low half = 0x0201, `stall` pattern 1,0,1,0.
